lcd_serial_seq: RTL and testbench

LCD_SERIAL_SEQ -- requirements
Module: lcd_serial_seq

---
 rtl/lcd_serial_seq_if.sv | 42 ++++
 rtl/lcd_serial_seq.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_lcd_serial_seq.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_serial_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_serial_seq_if
// Description : Host-side bundle for lcd_serial_seq. It carries the init-table
//               write port, the sequence length and restart request, the
//               ad-hoc word handshake, and the status flags.
//               master : host / controller side
//               slave  : lcd_serial_seq side
// Ports       : tbl_we_i, tbl_addr_i[AW], tbl_dat_i[WORD_W], tbl_len_i[AW+1],
//               start_i, cmd_valid_i, cmd_dat_i[WORD_W]  (host -> sequencer)
//               cmd_ready_o, busy_o, done_o, init_done_o  (sequencer -> host)
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_serial_seq_if #(
    parameter int WORD_W = 16,
    parameter int AW     = 5
);
    logic              tbl_we_i;
    logic [AW-1:0]     tbl_addr_i;
    logic [WORD_W-1:0] tbl_dat_i;
    logic [AW:0]       tbl_len_i;
    logic              start_i;
    logic              cmd_valid_i;
    logic [WORD_W-1:0] cmd_dat_i;
    logic              cmd_ready_o;
    logic              busy_o;
    logic              done_o;
    logic              init_done_o;

    modport master (
        output tbl_we_i, tbl_addr_i, tbl_dat_i, tbl_len_i,
        output start_i, cmd_valid_i, cmd_dat_i,
        input  cmd_ready_o, busy_o, done_o, init_done_o
    );

    modport slave (
        input  tbl_we_i, tbl_addr_i, tbl_dat_i, tbl_len_i,
        input  start_i, cmd_valid_i, cmd_dat_i,
        output cmd_ready_o, busy_o, done_o, init_done_o
    );
endinterface
`default_nettype wire

// File: rtl/lcd_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : lcd_serial_seq
// Description : LCD panel bring-up sequencer. Holds the panel in reset,
//               waits for startup, then shifts a programmable table of
//               WORD_W-bit words out over a 3-wire serial link (scen/scl/sda).
//               Afterwards it accepts single ad-hoc words and table reruns.
// Ports       : wb_clk_i     - sole clock, rising edge
//               wb_rst_n_i   - asynchronous active-low reset
//               host         - lcd_serial_seq_if.slave (table, cmd, status)
//               lcd_rst_n_o  - panel reset (low active)
//               lcd_scen_o   - serial enable (low active)
//               lcd_scl_o    - serial clock, data sampled on rising edge
//               lcd_sda_o    - serial data
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_serial_seq #(
    parameter int WORD_W      = 16,
    parameter int DEPTH       = 32,
    parameter int HALF_CYC    = 5000,
    parameter int RESET_CYC   = 1_000_000,
    parameter int STARTUP_CYC = 5_000_000,
    parameter int MSB_FIRST   = 1
) (
    input  wire logic         wb_clk_i,
    input  wire logic         wb_rst_n_i,
    lcd_serial_seq_if.slave   host,
    output logic              lcd_rst_n_o,
    output logic              lcd_scen_o,
    output logic              lcd_scl_o,
    output logic              lcd_sda_o
);

    // ------------------------------------------------------------------
    // Derived widths and terminal counts
    // ------------------------------------------------------------------
    localparam int c_AW      = $clog2(DEPTH);
    localparam int c_BW      = $clog2(WORD_W);
    localparam int c_CNT_MAX = (RESET_CYC > STARTUP_CYC)
                             ? ((RESET_CYC > HALF_CYC) ? RESET_CYC : HALF_CYC)
                             : ((STARTUP_CYC > HALF_CYC) ? STARTUP_CYC : HALF_CYC);
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_RESET_LAST = c_CW'(RESET_CYC - 1);
    localparam logic [c_CW-1:0] c_START_LAST = c_CW'(STARTUP_CYC - 1);
    localparam logic [c_CW-1:0] c_H_LAST     = c_CW'(HALF_CYC - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST   = c_BW'(WORD_W - 1);
    localparam logic [c_AW:0]   c_DEPTH_LEN  = (c_AW + 1)'(DEPTH);

    localparam logic [3:0] c_S_RESET_HOLD = 4'd0;
    localparam logic [3:0] c_S_STARTUP    = 4'd1;
    localparam logic [3:0] c_S_IDLE       = 4'd2;
    localparam logic [3:0] c_S_LOAD       = 4'd3;
    localparam logic [3:0] c_S_SETUP      = 4'd4;
    localparam logic [3:0] c_S_CLK_LO     = 4'd5;
    localparam logic [3:0] c_S_CLK_HI     = 4'd6;
    localparam logic [3:0] c_S_HOLD       = 4'd7;
    localparam logic [3:0] c_S_GAP        = 4'd8;

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [c_CW-1:0]   r_cnt;
    logic [c_BW-1:0]   r_bit;
    logic [WORD_W-1:0] r_shift;
    logic [c_AW:0]     r_idx;
    logic [c_AW:0]     r_len;
    logic              r_seq;        // 1: current word belongs to a table sequence
    logic              r_done;
    logic              r_init_done;

    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_phase_end;
    logic              w_seq_start;
    logic              w_seq_done;
    logic              w_cmd_acc;
    logic              w_idx_adv;
    logic [c_AW:0]     w_idx_inc;
    logic [c_AW:0]     w_len_clamp;
    logic              w_cur_bit;

    assign w_phase_end = (r_cnt == c_H_LAST);
    assign w_idx_inc   = r_idx + (c_AW + 1)'(1);
    assign w_len_clamp = (host.tbl_len_i > c_DEPTH_LEN) ? c_DEPTH_LEN : host.tbl_len_i;
    assign w_cur_bit   = (MSB_FIRST != 0) ? r_shift[WORD_W-1] : r_shift[0];

    // ------------------------------------------------------------------
    // Init table: written in every state and deliberately not reset, so a
    // panel reset replays the same contents.
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (host.tbl_we_i) begin
            r_mem[host.tbl_addr_i] <= host.tbl_dat_i;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= c_S_RESET_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic and sequencing strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_seq_start = 1'b0;
        w_seq_done  = 1'b0;
        w_cmd_acc   = 1'b0;
        w_idx_adv   = 1'b0;
        case (r_state)
            c_S_RESET_HOLD: begin
                if (r_cnt == c_RESET_LAST) begin
                    w_state_nxt = c_S_STARTUP;
                end
            end
            c_S_STARTUP: begin
                if (r_cnt == c_START_LAST) begin
                    w_seq_start = 1'b1;
                    if (w_len_clamp == '0) begin
                        w_seq_done  = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_state_nxt = c_S_LOAD;
                    end
                end
            end
            c_S_IDLE: begin
                // A restart has priority over a word offered in the same cycle
                if (host.start_i) begin
                    w_seq_start = 1'b1;
                    if (w_len_clamp == '0) begin
                        w_seq_done = 1'b1;
                    end else begin
                        w_state_nxt = c_S_LOAD;
                    end
                end else if (host.cmd_valid_i && r_init_done) begin
                    w_cmd_acc   = 1'b1;
                    w_state_nxt = c_S_LOAD;
                end
            end
            c_S_LOAD: begin
                w_state_nxt = c_S_SETUP;
            end
            c_S_SETUP: begin
                if (w_phase_end) begin
                    w_state_nxt = c_S_CLK_LO;
                end
            end
            c_S_CLK_LO: begin
                if (w_phase_end) begin
                    w_state_nxt = c_S_CLK_HI;
                end
            end
            c_S_CLK_HI: begin
                if (w_phase_end) begin
                    w_state_nxt = (r_bit == c_BIT_LAST) ? c_S_HOLD : c_S_CLK_LO;
                end
            end
            c_S_HOLD: begin
                if (w_phase_end) begin
                    w_state_nxt = c_S_GAP;
                end
            end
            c_S_GAP: begin
                if (w_phase_end) begin
                    if (r_seq) begin
                        w_idx_adv = 1'b1;
                        if (w_idx_inc < r_len) begin
                            w_state_nxt = c_S_LOAD;
                        end else begin
                            w_seq_done  = 1'b1;
                            w_state_nxt = c_S_IDLE;
                        end
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_S_RESET_HOLD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: phase counter, bit counter, shift register, table index
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            r_seq       <= 1'b0;
            r_done      <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            // Counter restarts on every state change; parked at 0 in IDLE
            if ((w_state_nxt != r_state) || (r_state == c_S_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CW'(1);
            end

            r_done <= w_seq_done;
            if (w_seq_done) begin
                r_init_done <= 1'b1;
            end

            if (w_seq_start) begin
                r_len <= w_len_clamp;
                r_idx <= '0;
                r_seq <= 1'b1;
            end else if (w_cmd_acc) begin
                r_seq   <= 1'b0;
                r_shift <= host.cmd_dat_i;
            end

            if (w_idx_adv) begin
                r_idx <= w_idx_inc;
            end

            // The table word is captured here, so later writes to the
            // same entry cannot disturb the word on the wire.
            if (r_state == c_S_LOAD) begin
                r_bit <= '0;
                if (r_seq) begin
                    r_shift <= r_mem[r_idx[c_AW-1:0]];
                end
            end else if ((r_state == c_S_CLK_HI) && w_phase_end && (r_bit != c_BIT_LAST)) begin
                // No shift after the final bit: HOLD keeps the last bit on sda
                r_bit <= r_bit + c_BW'(1);
                if (MSB_FIRST != 0) begin
                    r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                end else begin
                    r_shift <= {1'b0, r_shift[WORD_W-1:1]};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        lcd_rst_n_o      = 1'b1;
        lcd_scen_o       = 1'b1;
        lcd_scl_o        = 1'b0;
        lcd_sda_o        = 1'b1;
        host.busy_o      = (r_state != c_S_IDLE);
        host.done_o      = r_done;
        host.init_done_o = r_init_done;
        host.cmd_ready_o = (r_state == c_S_IDLE) && r_init_done && !host.start_i;
        case (r_state)
            c_S_RESET_HOLD: begin
                lcd_rst_n_o = 1'b0;
            end
            c_S_LOAD: begin
                lcd_scen_o = 1'b0;
            end
            c_S_SETUP, c_S_CLK_LO, c_S_HOLD: begin
                lcd_scen_o = 1'b0;
                lcd_sda_o  = w_cur_bit;
            end
            c_S_CLK_HI: begin
                lcd_scen_o = 1'b0;
                lcd_scl_o  = 1'b1;
                lcd_sda_o  = w_cur_bit;
            end
            default: begin
                lcd_scen_o = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_serial_seq
// Description : Self-checking bench for lcd_serial_seq (H=2, WORD_W=16,
//               RESET_CYC=4, STARTUP_CYC=8). One MSB-first instance runs the
//               directed flow; a second LSB-first instance sends one word.
//               Expected serial words are queued when stimulus is issued and
//               popped by frame monitors watching scen/scl/sda.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_serial_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_l_n;
    always #5 clk = ~clk;

    lcd_serial_seq_if #(.WORD_W(16), .AW(5)) if_m ();
    lcd_serial_seq_if #(.WORD_W(16), .AW(5)) if_l ();

    logic rst_m_o, scen_m, scl_m, sda_m;
    logic rst_l_o, scen_l, scl_l, sda_l;

    lcd_serial_seq #(
        .WORD_W(16), .DEPTH(32), .HALF_CYC(2), .RESET_CYC(4),
        .STARTUP_CYC(8), .MSB_FIRST(1)
    ) dut_m (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .host(if_m),
        .lcd_rst_n_o(rst_m_o), .lcd_scen_o(scen_m),
        .lcd_scl_o(scl_m), .lcd_sda_o(sda_m)
    );

    lcd_serial_seq #(
        .WORD_W(16), .DEPTH(32), .HALF_CYC(2), .RESET_CYC(4),
        .STARTUP_CYC(8), .MSB_FIRST(0)
    ) dut_l (
        .wb_clk_i(clk), .wb_rst_n_i(rst_l_n), .host(if_l),
        .lcd_rst_n_o(rst_l_o), .lcd_scen_o(scen_l),
        .lcd_scl_o(scl_l), .lcd_sda_o(sda_l)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboards and frame monitors
    // ------------------------------------------------------------------
    logic [15:0] exp_m[$];
    logic [15:0] exp_l[$];
    int done_cnt_m = 0;
    int done_cnt_l = 0;
    int rise_m = 0;

    logic        in_m = 0, prev_m = 0;
    logic [15:0] acc_m;
    int          low_m, bits_m;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_m = 0; prev_m = 0; rise_m = 0;
        end else begin
            if (if_m.done_o) done_cnt_m++;
            if (!scen_m && !in_m) begin
                in_m = 1; acc_m = '0; low_m = 0; bits_m = 0; rise_m = 0;
            end
            if (in_m) begin
                if (scen_m) begin
                    in_m = 0;
                    chk("m_scen_low_cycles", low_m, 69);
                    chk("m_scl_rises", bits_m, 16);
                    if (exp_m.size() == 0) begin
                        chk("m_unexpected_frame", acc_m, 32'hFFFF_FFFF);
                    end else begin
                        chk("m_word", acc_m, exp_m.pop_front());
                    end
                end else begin
                    low_m++;
                    if (scl_m && !prev_m) begin
                        acc_m = {acc_m[14:0], sda_m};
                        bits_m++;
                        rise_m++;
                    end
                end
            end
            prev_m = scl_m;
        end
    end

    logic        in_l = 0, prev_l = 0, first_l = 0;
    logic [15:0] acc_l;
    int          low_l, bits_l;

    always @(negedge clk) begin
        if (!rst_l_n) begin
            in_l = 0; prev_l = 0;
        end else begin
            if (if_l.done_o) done_cnt_l++;
            if (!scen_l && !in_l) begin
                in_l = 1; acc_l = '0; low_l = 0; bits_l = 0;
            end
            if (in_l) begin
                if (scen_l) begin
                    in_l = 0;
                    chk("l_scen_low_cycles", low_l, 69);
                    chk("l_scl_rises", bits_l, 16);
                    chk("l_first_bit", first_l, 1);
                    if (exp_l.size() == 0) begin
                        chk("l_unexpected_frame", acc_l, 32'hFFFF_FFFF);
                    end else begin
                        chk("l_word", acc_l, exp_l.pop_front());
                    end
                end else begin
                    low_l++;
                    if (scl_l && !prev_l) begin
                        if (bits_l == 0) first_l = sda_l;
                        acc_l = {sda_l, acc_l[15:1]};
                        bits_l++;
                    end
                end
            end
            prev_l = scl_l;
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (!if_m.done_o && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle(input int budget, output int k);
        k = 0;
        while (if_m.busy_o && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wr_m(input logic [4:0] a, input logic [15:0] d);
        if_m.tbl_we_i = 1; if_m.tbl_addr_i = a; if_m.tbl_dat_i = d;
        @(negedge clk);
        if_m.tbl_we_i = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int k;
        rst_n = 0; rst_l_n = 0;
        if_m.tbl_we_i = 0; if_m.tbl_addr_i = '0; if_m.tbl_dat_i = '0; if_m.tbl_len_i = 6'd2;
        if_m.start_i = 0; if_m.cmd_valid_i = 0; if_m.cmd_dat_i = '0;
        if_l.tbl_we_i = 0; if_l.tbl_addr_i = '0; if_l.tbl_dat_i = '0; if_l.tbl_len_i = 6'd1;
        if_l.start_i = 0; if_l.cmd_valid_i = 0; if_l.cmd_dat_i = '0;

        // Table loads while in reset
        @(negedge clk);
        wr_m(5'd0, 16'h4505);
        wr_m(5'd1, 16'h486A);
        if_l.tbl_we_i = 1; if_l.tbl_addr_i = 5'd0; if_l.tbl_dat_i = 16'h0001;
        @(negedge clk);
        if_l.tbl_we_i = 0;

        chk("rst_lcd_rst_n", rst_m_o, 0);
        chk("rst_scen", scen_m, 1);
        chk("rst_scl", scl_m, 0);
        chk("rst_sda", sda_m, 1);
        chk("rst_busy", if_m.busy_o, 1);
        chk("rst_done", if_m.done_o, 0);
        chk("rst_init_done", if_m.init_done_o, 0);
        chk("rst_cmd_ready", if_m.cmd_ready_o, 0);

        // Power-up sequence with two table entries
        exp_m.push_back(16'h4505);
        exp_m.push_back(16'h486A);
        exp_l.push_back(16'h0001);
        rst_n = 1; rst_l_n = 1;
        repeat (3) @(negedge clk);
        chk("panel_rst_held", rst_m_o, 0);
        @(negedge clk);
        chk("panel_rst_released", rst_m_o, 1);
        repeat (7) @(negedge clk);
        chk("startup_scen_idle", scen_m, 1);
        @(negedge clk);
        chk("load_scen_low", scen_m, 0);
        wait_done(400, k);
        chk("seq_done_latency", k, 142);
        chk("seq_init_done", if_m.init_done_o, 1);
        chk("seq_idle_busy", if_m.busy_o, 0);
        @(negedge clk);
        chk("seq_done_one_cycle", if_m.done_o, 0);
        chk("seq_cmd_ready", if_m.cmd_ready_o, 1);

        // Ad-hoc word, plus a start pulse outside IDLE that must be ignored
        if_m.cmd_valid_i = 1; if_m.cmd_dat_i = 16'hA5C3;
        exp_m.push_back(16'hA5C3);
        @(negedge clk);
        if_m.cmd_valid_i = 0;
        chk("cmd_ready_in_frame", if_m.cmd_ready_o, 0);
        chk("cmd_busy", if_m.busy_o, 1);
        if_m.start_i = 1;
        @(negedge clk);
        if_m.start_i = 0;
        wait_idle(200, k);
        chk("cmd_frame_len", k, 70);
        chk("cmd_no_done", done_cnt_m, 1);

        // start and cmd_valid together: rerun first, word afterwards.
        // Entry 1 is overwritten while its frame is on the wire.
        if_m.start_i = 1; if_m.cmd_valid_i = 1; if_m.cmd_dat_i = 16'h1234;
        #1;
        chk("start_blocks_ready", if_m.cmd_ready_o, 0);
        exp_m.push_back(16'h4505);
        exp_m.push_back(16'h486A);
        exp_m.push_back(16'h1234);
        @(negedge clk);
        if_m.start_i = 0;
        repeat (79) @(negedge clk);
        chk("rerun_init_done_kept", if_m.init_done_o, 1);
        chk("rerun_cmd_wait", if_m.cmd_ready_o, 0);
        wr_m(5'd1, 16'hFFFF);
        wait_done(400, k);
        chk("rerun_done_seen", (k < 400), 1);
        @(negedge clk);
        if_m.cmd_valid_i = 0;
        if_m.tbl_we_i = 1; if_m.tbl_addr_i = 5'd1; if_m.tbl_dat_i = 16'h486A;
        @(negedge clk);
        if_m.tbl_we_i = 0;
        wait_idle(200, k);
        chk("late_cmd_frame_len", k, 70);
        chk("rerun_done_count", done_cnt_m, 2);

        // Reset in the middle of a frame
        if_m.start_i = 1;
        @(negedge clk);
        if_m.start_i = 0;
        k = 0;
        while (rise_m < 7 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("midframe_reached", (k < 200), 1);
        #3 rst_n = 0;
        #1;
        chk("abort_lcd_rst_n", rst_m_o, 0);
        chk("abort_scen", scen_m, 1);
        chk("abort_scl", scl_m, 0);
        chk("abort_sda", sda_m, 1);
        chk("abort_busy", if_m.busy_o, 1);
        chk("abort_done", if_m.done_o, 0);
        chk("abort_init_done", if_m.init_done_o, 0);
        chk("abort_cmd_ready", if_m.cmd_ready_o, 0);
        repeat (2) @(negedge clk);
        exp_m.push_back(16'h4505);
        exp_m.push_back(16'h486A);
        rst_n = 1;
        wait_done(400, k);
        chk("replay_done_latency", k, 154);
        chk("replay_init_done", if_m.init_done_o, 1);
        @(negedge clk);
        chk("replay_done_count", done_cnt_m, 3);

        // Empty table
        if_m.tbl_len_i = 6'd0;
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        wait_done(100, k);
        chk("len0_done_latency", k, 12);
        chk("len0_scen", scen_m, 1);
        @(negedge clk);
        chk("len0_done_one_cycle", if_m.done_o, 0);
        chk("len0_cmd_ready", if_m.cmd_ready_o, 1);
        repeat (4) @(negedge clk);
        chk("len0_done_count", done_cnt_m, 4);

        chk("m_queue_drained", exp_m.size(), 0);
        chk("l_queue_drained", exp_l.size(), 0);
        chk("l_done_count", done_cnt_l, 1);
        chk("l_init_done", if_l.init_done_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
